// File: rtl/vtscroll_if.sv
`timescale 1ns/1ps
// vtscroll_if: register-slave and memory-master bus bundle for the vtscroll text engine.
// Latency: none (signal bundle only).
// Backpressure: master side stalls on m_ack_i; slave side always acknowledges one cycle after request.
// Ports: wb_* = register slave bus, m_* = text-buffer master bus, irq = completion interrupt.
// Modports: slave = engine side, master = system side (register host + text memory).
interface vtscroll_if;
  // register slave bus
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_ack_o;
  // text-buffer master bus
  logic [15:0] m_adr_o;
  logic [15:0] m_dat_o;
  logic [15:0] m_dat_i;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [1:0]  m_sel_o;
  logic        m_ack_i;
  // completion interrupt
  logic        irq;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o,
    output m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    input  m_dat_i, m_ack_i,
    output irq
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o,
    input  m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    output m_dat_i, m_ack_i,
    input  irq
  );
endinterface

// File: rtl/vtscroll.sv
`timescale 1ns/1ps
// vtscroll: text-mode buffer engine -- clears the screen or scrolls it up one row over a master bus.
// Latency: register access acked 1 cycle after request; each buffer access is followed by a 1-cycle bus gap.
// Backpressure: master accesses hold address/data/strobe until m_ack_i; no register-side stall.
// Ports: wb_clk_i clock, wb_rst_i synchronous active-high reset, bus (vtscroll_if.slave) carries
//        the register slave bus (CSR at adr[1]=0, FILL at adr[1]=1), the buffer master bus and irq.
// Build option: define VTSCROLL_PROTECT_EN to keep row 0 (service line) out of clear and scroll.
module vtscroll #(
  parameter logic [15:0] VBASE = 16'h0000,
  parameter int          NCOL  = 80,
  parameter int          NROW  = 25
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  vtscroll_if.slave   bus
);

  localparam int ROWW   = NCOL / 2;          // words per text row
  localparam int NWORDS = NROW * ROWW;       // words per screen
  localparam int CW     = $clog2(NWORDS + 1);
`ifdef VTSCROLL_PROTECT_EN
  localparam int FIRST  = ROWW;
`else
  localparam int FIRST  = 0;
`endif
  localparam int LSTART = NWORDS - ROWW;     // first word of the bottom row

  localparam logic [CW-1:0] FIRST_W  = CW'(FIRST);
  localparam logic [CW-1:0] LSTART_W = CW'(LSTART);
  localparam logic [CW-1:0] LAST_W   = CW'(NWORDS - 1);
  localparam logic [CW-1:0] ROWW_W   = CW'(ROWW);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, GAP, FIN} state_t;

  state_t        state_q, state_d;
  state_t        resume_q, resume_d;     // access to issue when GAP ends
  logic [CW-1:0] idx_q, idx_d;           // destination word index
  logic [15:0]   rdat_q, rdat_d;         // word captured by the last RD
  logic [1:0]    cmd_q, cmd_d;
  logic          ie_q, ie_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   fill_q, fill_d;         // FILL register as seen by software
  logic [15:0]   fill_run_q, fill_run_d; // copy frozen for the running operation
  logic          ack_q, ack_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic          m_cyc_q, m_cyc_d;
  logic          m_we_q, m_we_d;
  logic [15:0]   m_adr_q, m_adr_d;
  logic [15:0]   m_dat_q, m_dat_d;

  logic          req;
  logic          start;
  logic [1:0]    start_cmd;
  logic [15:0]   csr_rd;
  logic [CW-1:0] idx_inc;
  logic          unused_adr;

  // Only address bit 1 selects a register.
  assign unused_adr = ^{bus.wb_adr_i[15:2], bus.wb_adr_i[0]};

  assign req     = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign csr_rd  = {6'b0, err_q, done_q, busy_q, ie_q, 3'b000, cmd_q, 1'b0};
  assign idx_inc = idx_q + 1'b1;

  function automatic logic [15:0] word_addr(input logic [CW-1:0] w);
    logic [15:0] w16;
    w16 = 16'(w);
    return VBASE + {w16[14:0], 1'b0};
  endfunction

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    idx_d      = idx_q;
    rdat_d     = rdat_q;
    cmd_d      = cmd_q;
    ie_d       = ie_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    fill_d     = fill_q;
    fill_run_d = fill_run_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    m_cyc_d    = m_cyc_q;
    m_we_d     = m_we_q;
    m_adr_d    = m_adr_q;
    m_dat_d    = m_dat_q;
    start      = 1'b0;
    start_cmd  = cmd_q;

    // Register slave: side effects happen on the request cycle, ack and read data follow.
    if (req) begin
      ack_d = 1'b1;
      if (bus.wb_we_i) begin
        if (bus.wb_adr_i[1]) begin
          if (bus.wb_sel_i[0]) fill_d[7:0]  = bus.wb_dat_i[7:0];
          if (bus.wb_sel_i[1]) fill_d[15:8] = bus.wb_dat_i[15:8];
        end else begin
          // Clears go first so a GO-while-busy in the same write still leaves ERR set.
          if (bus.wb_sel_i[1]) begin
            if (bus.wb_dat_i[8]) done_d = 1'b0;
            if (bus.wb_dat_i[9]) err_d  = 1'b0;
          end
          if (bus.wb_sel_i[0]) begin
            ie_d = bus.wb_dat_i[6];
            if (busy_q) begin
              // CMD is frozen while an operation runs; a second GO only flags ERR.
              if (bus.wb_dat_i[0]) err_d = 1'b1;
            end else begin
              cmd_d = bus.wb_dat_i[2:1];
              if (bus.wb_dat_i[0]) begin
                start     = 1'b1;
                start_cmd = bus.wb_dat_i[2:1];
              end
            end
          end
        end
      end else begin
        rdata_d = bus.wb_adr_i[1] ? fill_q : csr_rd;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          fill_run_d = fill_q;
          idx_d      = FIRST_W;
          unique case (start_cmd)
            2'b10: begin
              if (FIRST < LSTART) begin
                state_d = RD;
                m_cyc_d = 1'b1;
                m_we_d  = 1'b0;
                m_adr_d = word_addr(FIRST_W + ROWW_W);
              end else begin
                // Nothing to copy: go straight to blanking the bottom row.
                idx_d   = LSTART_W;
                state_d = FILL;
                m_cyc_d = 1'b1;
                m_we_d  = 1'b1;
                m_adr_d = word_addr(LSTART_W);
                m_dat_d = fill_q;
              end
            end
            2'b01: begin
              state_d = FILL;
              m_cyc_d = 1'b1;
              m_we_d  = 1'b1;
              m_adr_d = word_addr(FIRST_W);
              m_dat_d = fill_q;
            end
            default: state_d = FIN;
          endcase
        end
      end
      RD: begin
        if (bus.m_ack_i) begin
          rdat_d   = bus.m_dat_i;
          m_cyc_d  = 1'b0;
          resume_d = WR;
          state_d  = GAP;
        end
      end
      WR: begin
        if (bus.m_ack_i) begin
          m_cyc_d  = 1'b0;
          idx_d    = idx_inc;
          resume_d = (idx_inc < LSTART_W) ? RD : FILL;
          state_d  = GAP;
        end
      end
      FILL: begin
        if (bus.m_ack_i) begin
          m_cyc_d = 1'b0;
          state_d = GAP;
          if (idx_q == LAST_W) begin
            resume_d = FIN;
          end else begin
            idx_d    = idx_inc;
            resume_d = FILL;
          end
        end
      end
      GAP: begin
        case (resume_q)
          RD: begin
            state_d = RD;
            m_cyc_d = 1'b1;
            m_we_d  = 1'b0;
            m_adr_d = word_addr(idx_q + ROWW_W);
          end
          WR: begin
            state_d = WR;
            m_cyc_d = 1'b1;
            m_we_d  = 1'b1;
            m_adr_d = word_addr(idx_q);
            m_dat_d = rdat_q;
          end
          FILL: begin
            state_d = FILL;
            m_cyc_d = 1'b1;
            m_we_d  = 1'b1;
            m_adr_d = word_addr(idx_q);
            m_dat_d = fill_run_q;
          end
          default: state_d = FIN;
        endcase
      end
      FIN: begin
        // Completion wins over a same-cycle DONE clear.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    irq_d = done_d & ie_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      resume_q   <= IDLE;
      idx_q      <= '0;
      rdat_q     <= '0;
      cmd_q      <= 2'b00;
      ie_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fill_q     <= 16'h0020;
      fill_run_q <= 16'h0020;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      m_cyc_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= '0;
      m_dat_q    <= '0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      idx_q      <= idx_d;
      rdat_q     <= rdat_d;
      cmd_q      <= cmd_d;
      ie_q       <= ie_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fill_q     <= fill_d;
      fill_run_q <= fill_run_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      m_cyc_q    <= m_cyc_d;
      m_we_q     <= m_we_d;
      m_adr_q    <= m_adr_d;
      m_dat_q    <= m_dat_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = rdata_q;
  assign bus.irq      = irq_q;
  assign bus.m_cyc_o  = m_cyc_q;
  assign bus.m_stb_o  = m_cyc_q;
  assign bus.m_we_o   = m_we_q;
  assign bus.m_adr_o  = m_adr_q;
  assign bus.m_dat_o  = m_dat_q;
  assign bus.m_sel_o  = 2'b11;

endmodule
